// File: rtl/common_stream_output_pkg.sv
// Shared types and constants for the stream output adapter.
package common_stream_output_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_IN_PACKET
  } state_e;

  localparam int unsigned FIFO_DEPTH  = 2;
  localparam int unsigned COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; entry 0 is always the head. Beats are {data, sop, eop} packed.
module stream_fifo2
  import common_stream_output_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH+1:0] beat_in,
  output logic [DATA_WIDTH+1:0] head,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH+1:0]  mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH+1:0]  mem_d [FIFO_DEPTH];
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_WIDTH'(FIFO_DEPTH));
  assign head  = mem_q[0];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    do_push = push && !full;
    do_pop  = pop && !empty;
    case ({do_push, do_pop})
      2'b10: begin
        mem_d[count_q[0]] = beat_in;
        count_d           = count_q + COUNT_WIDTH'(1);
      end
      2'b01: begin
        mem_d[0] = mem_q[1];
        count_d  = count_q - COUNT_WIDTH'(1);
      end
      // Both only possible with one entry held: new beat replaces the departing head.
      2'b11: mem_d[0] = beat_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/common_stream_output.sv
// Core-to-Avalon-ST egress adapter with packet-boundary enable gating.
// COMMON_STREAM_OUTPUT_ORPHAN_DROP_EN: discard non-sop beats arriving outside a packet.
module common_stream_output #(
  parameter int unsigned DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  int_ready,
  input  logic                  int_valid,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic                  int_sop,
  input  logic                  int_eop,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  input  logic                  enable,
  output logic                  synced
);

  import common_stream_output_pkg::*;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
  } beat_t;

  beat_t  in_beat, head;
  logic   empty, full, push, pop, fwd, drop;
  state_e state_q, state_d;

  assign in_beat   = '{data: int_data, sop: int_sop, eop: int_eop};
  assign int_ready = !full;
  assign push      = int_valid && int_ready;
  assign pop       = fwd || drop;

  stream_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .beat_in(in_beat),
    .head   (head),
    .empty  (empty),
    .full   (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (fwd) begin
      if (head.eop)      state_d = ST_IDLE;
      else if (head.sop) state_d = ST_IN_PACKET;
    end
  end

  always_comb begin
    fwd    = 1'b0;
    drop   = 1'b0;
    synced = (state_q == ST_IDLE);
    if (!empty) begin
`ifdef COMMON_STREAM_OUTPUT_ORPHAN_DROP_EN
      if (state_q == ST_IDLE && !head.sop) drop = 1'b1;
      else fwd = dout_ready && (state_q == ST_IN_PACKET || enable);
`else
      // An orphan head in IDLE is forwarded as if mid-packet and ignores enable.
      fwd = dout_ready && (state_q == ST_IN_PACKET || !head.sop || enable);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
    end else begin
      dout_valid <= fwd;
      if (fwd) begin
        dout_data <= head.data;
        dout_sop  <= head.sop;
        dout_eop  <= head.eop;
      end
    end
  end

endmodule

// File: tb/tb_common_stream_output.sv
// Directed, table-driven bench for common_stream_output plus hand-written reset sequences.
module tb_common_stream_output;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_ready, int_valid, int_sop, int_eop;
  logic [9:0] int_data;
  logic       dout_ready, dout_valid, dout_sop, dout_eop;
  logic [9:0] dout_data;
  logic       enable, synced;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  common_stream_output #(
    .DATA_WIDTH(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .int_ready (int_ready),
    .int_valid (int_valid),
    .int_data  (int_data),
    .int_sop   (int_sop),
    .int_eop   (int_eop),
    .dout_ready(dout_ready),
    .dout_valid(dout_valid),
    .dout_data (dout_data),
    .dout_sop  (dout_sop),
    .dout_eop  (dout_eop),
    .enable    (enable),
    .synced    (synced)
  );

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       s, e, r, en;
    logic       ev;
    logic [9:0] ed;
    logic       es, ee, eir, esy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input logic s, input logic e,
                       input logic r, input logic en);
    int_valid  = v;
    int_data   = d;
    int_sop    = s;
    int_eop    = e;
    dout_ready = r;
    enable     = en;
  endtask

  task automatic add(input logic v, input logic [9:0] d, input logic s, input logic e,
                     input logic r, input logic en, input logic ev, input logic [9:0] ed,
                     input logic es, input logic ee, input logic eir, input logic esy);
    vec_t x;
    x = '{v: v, d: d, s: s, e: e, r: r, en: en,
          ev: ev, ed: ed, es: es, ee: ee, eir: eir, esy: esy};
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Ready latency: 4-beat packet back-to-back
    add(1, 10'h001, 1, 0, 1, 1,  0, 10'h000, 0, 0, 1, 1);
    add(1, 10'h002, 0, 0, 1, 1,  1, 10'h001, 1, 0, 1, 0);
    add(1, 10'h003, 0, 0, 1, 1,  1, 10'h002, 0, 0, 1, 0);
    add(1, 10'h004, 0, 1, 1, 1,  1, 10'h003, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h004, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h004, 0, 1, 1, 1);
    // Backpressure: dout_ready low for 3 cycles mid-packet; 0x014 held while int_ready low
    add(1, 10'h011, 1, 0, 1, 1,  0, 10'h004, 0, 1, 1, 1);
    add(1, 10'h012, 0, 0, 1, 1,  1, 10'h011, 1, 0, 1, 0);
    add(1, 10'h013, 0, 0, 0, 1,  0, 10'h011, 1, 0, 0, 0);
    add(1, 10'h014, 0, 0, 0, 1,  0, 10'h011, 1, 0, 0, 0);
    add(1, 10'h014, 0, 0, 0, 1,  0, 10'h011, 1, 0, 0, 0);
    add(1, 10'h014, 0, 0, 1, 1,  1, 10'h012, 0, 0, 1, 0);
    add(1, 10'h014, 0, 0, 1, 1,  1, 10'h013, 0, 0, 1, 0);
    add(1, 10'h015, 0, 1, 1, 1,  1, 10'h014, 0, 0, 1, 0);
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h015, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h015, 0, 1, 1, 1);
    // Enable gating: single-beat packet held until enable rises
    add(1, 10'h100, 1, 1, 1, 0,  0, 10'h015, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 0,  0, 10'h015, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h100, 1, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h100, 1, 1, 1, 1);
    // Enable drop mid-packet: packet completes, next sop held
    add(1, 10'h201, 1, 0, 1, 1,  0, 10'h100, 1, 1, 1, 1);
    add(1, 10'h202, 0, 0, 1, 1,  1, 10'h201, 1, 0, 1, 0);
    add(1, 10'h203, 0, 1, 1, 0,  1, 10'h202, 0, 0, 1, 0);
    add(1, 10'h301, 1, 0, 1, 0,  1, 10'h203, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 0,  0, 10'h203, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 0,  0, 10'h203, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h301, 1, 0, 1, 0);
    add(1, 10'h302, 0, 1, 1, 1,  0, 10'h301, 1, 0, 1, 0);
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h302, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h302, 0, 1, 1, 1);
    // Orphan beat in IDLE
    add(1, 10'h055, 0, 0, 1, 1,  0, 10'h302, 0, 1, 1, 1);
`ifdef COMMON_STREAM_OUTPUT_ORPHAN_DROP_EN
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h302, 0, 1, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h302, 0, 1, 1, 1);
`else
    add(0, 10'h000, 0, 0, 1, 1,  1, 10'h055, 0, 0, 1, 1);
    add(0, 10'h000, 0, 0, 1, 1,  0, 10'h055, 0, 0, 1, 1);
`endif

    step();
    step();
    check("reset dout_valid", 32'(dout_valid), 32'd0);
    check("reset dout_data", 32'(dout_data), 32'd0);
    check("reset dout_sop", 32'(dout_sop), 32'd0);
    check("reset dout_eop", 32'(dout_eop), 32'd0);
    check("reset int_ready", 32'(int_ready), 32'd1);
    check("reset synced", 32'(synced), 32'd1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].e, vecs[i].r, vecs[i].en);
      step();
      check($sformatf("vec%0d dout_valid", i), 32'(dout_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d dout_data", i), 32'(dout_data), 32'(vecs[i].ed));
      check($sformatf("vec%0d dout_sop", i), 32'(dout_sop), 32'(vecs[i].es));
      check($sformatf("vec%0d dout_eop", i), 32'(dout_eop), 32'(vecs[i].ee));
      check($sformatf("vec%0d int_ready", i), 32'(int_ready), 32'(vecs[i].eir));
      check($sformatf("vec%0d synced", i), 32'(synced), 32'(vecs[i].esy));
    end

    // Async reset while a beat is being presented
    drive(1'b1, 10'h401, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b1, 10'h402, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("rstA pre dout_valid", 32'(dout_valid), 32'd1);
    check("rstA pre synced", 32'(synced), 32'd0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstA async dout_valid", 32'(dout_valid), 32'd0);
    check("rstA async dout_data", 32'(dout_data), 32'd0);
    step();
    rst = 1'b0;
    check("rstA post int_ready", 32'(int_ready), 32'd1);
    check("rstA post synced", 32'(synced), 32'd1);

    // Async reset with FIFO full and a packet in flight
    drive(1'b1, 10'h411, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b1, 10'h412, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    drive(1'b1, 10'h413, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("rstB full int_ready", 32'(int_ready), 32'd0);
    check("rstB full synced", 32'(synced), 32'd0);
    drive(1'b0, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstB async dout_valid", 32'(dout_valid), 32'd0);
    check("rstB async int_ready", 32'(int_ready), 32'd1);
    step();
    rst = 1'b0;
    check("rstB post synced", 32'(synced), 32'd1);
    step();
    check("rstB fifo lost dout_valid", 32'(dout_valid), 32'd0);
    check("rstB fifo lost int_ready", 32'(int_ready), 32'd1);
    step();
    check("rstB fifo lost dout_valid 2", 32'(dout_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/common_stream_output.md
# common_stream_output

Transmit-side adapter for the VIP internal streaming interface. It accepts beats from the core on a ready/valid handshake with zero latency, buffers them in a 2-entry register FIFO, and drives an Avalon-ST output with ready latency 1 and fully registered outputs. It also gates output at packet boundaries under `enable`, so a core can be stopped or started without emitting a truncated packet. It sits at the egress of every VIP core, mirroring the stream input adapter at ingress.

## Interface
- `DATA_WIDTH`, default 10: beat data width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `int_ready`  out  1  core may present a beat; a transfer occurs when `int_valid && int_ready`
- `int_valid`  in  1  core beat valid
- `int_data`  in  DATA_WIDTH  core beat data
- `int_sop`  in  1  core start of packet
- `int_eop`  in  1  core end of packet
- `dout_ready`  in  1  downstream ready, ready latency 1
- `dout_valid`  out  1  registered beat valid
- `dout_data`  out  DATA_WIDTH  registered data
- `dout_sop`  out  1  registered start of packet
- `dout_eop`  out  1  registered end of packet
- `enable`  in  1  permits starting a new packet
- `synced`  out  1  high when no packet is in flight on `dout` (state IDLE)

## Operation
- **FIFO**
  - 2 entries holding {data, sop, eop}.
  - `int_ready = (count != 2)`, a function of registered count only. There is no combinational path from `dout_ready`.
- **Pop decision** (each cycle; head = oldest entry):
  - FIFO non-empty.
  - `dout_ready` high in this cycle.
  - Gate open: state IN_PACKET, or head has sop and `enable`=1.
- **Pop effect:** at the next edge the head loads into the `dout_*` registers and `dout_valid`<=1. With no pop, `dout_valid`<=0 and data/sop/eop hold their last values.
- **State machine**
  - IDLE -> IN_PACKET on popping a sop beat without eop.
  - IN_PACKET -> IDLE on popping an eop beat.
  - A sop+eop beat leaves the state at IDLE.
  - A sop beat popped in IN_PACKET is forwarded unchanged and the state stays IN_PACKET. The unterminated packet is not repaired.
- `synced` = (state == IDLE); it is registered.
- `enable` is sampled only when a sop beat is at the head in IDLE. Deasserting `enable` mid-packet does not stop that packet.
- **Orphan beat:** head has no sop while in IDLE. Handling is set under Configuration.
- Simultaneous push and pop when count is 1: count stays 1 and the order is preserved.

## Timing
- **Reset values:** `dout_valid`=0, `dout_data`=0, `dout_sop`=0, `dout_eop`=0, `int_ready`=1, `synced`=1, FIFO empty, state IDLE.
- **Reset mid-operation:** FIFO contents are lost and `dout_valid` drops asynchronously. Any partial packet is abandoned.
- **Latency:** a beat accepted at edge E appears on `dout` at the earliest after edge E+1 (2 cycles).
- **Throughput:** 1 beat/cycle is sustained while `dout_ready`=1 and the gate is open, with steady-state count of 1.
- **Protocol:** `dout_valid` may be high in cycle N+1 only if `dout_ready` was high in cycle N. This is guaranteed because popping requires `dout_ready`.
- **Backpressure:** `dout_ready` low for a cycle stops popping. The FIFO fills to 2 within 2 cycles and `int_ready` falls the cycle after count reaches 2.

## Configuration
- Macro: `COMMON_STREAM_OUTPUT_ORPHAN_DROP_EN`.
- **Defined:** an orphan head is popped and discarded. No `dout_valid` is produced, the state stays IDLE, and the discard takes 1 cycle regardless of `dout_ready` and `enable`.
- **Undefined:** an orphan head is treated as mid-packet and forwarded under the normal pop rules (needs `dout_ready`, ignores `enable`), and the state stays IDLE.

## Structure
- **Shared package:**
  - state enum {ST_IDLE, ST_IN_PACKET}
  - `FIFO_DEPTH`=2
  - beat struct {data, sop, eop}, parameterised via `DATA_WIDTH` at module level
- **Sub-module:** `stream_fifo2` (2-entry register FIFO)
  - inputs: push, pop, beat in
  - outputs: head beat, empty, full
  - asynchronous reset to empty
- **Top:** gate FSM, pop logic and output registers.

## Test plan
- **Ready latency:** reset, `enable`=1, `dout_ready`=1, push a 4-beat packet (sop on 0x001, eop on 0x004) back-to-back -> `dout_valid` high for 4 consecutive cycles starting 2 cycles after the first accept, with `synced` low between sop and eop.
- **Backpressure:** `dout_ready` low 3 cycles mid-packet -> `int_ready` falls after 2 buffered beats, no `dout_valid` in the cycles following a low `dout_ready`, and no beat lost or duplicated.
- **Enable gating:** `enable`=0 with a sop beat 0x100 queued -> no output and `synced`=1. Then `enable`=1 -> 0x100 appears 1 cycle later with `dout_sop`=1.
- **Enable drop mid-packet:** `enable` falls after the sop -> the packet completes through eop, and the next sop is held.
- **Orphan beat:** push non-sop beat 0x055 in IDLE -> with the macro, no `dout_valid` at all; without it, 0x055 is output with `dout_sop`=0 and `synced` stays 1.
- **Async reset:** assert `rst` while count is 2 and IN_PACKET -> `dout_valid`=0 immediately, then `int_ready`=1 and `synced`=1 after release.
